// File: rtl/burst_repeat.sv
// Token repeater: accepts one (data, cnt) token and replays the data as cnt indexed beats.
// A zero count drops the token. The next token is handed off on the last beat, so there is no bubble.
module burst_repeat #(
  parameter int unsigned DW = 16,
  parameter int unsigned CW = 8
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          src_rdy,
  output logic          src_ack,
  input  logic [DW-1:0] src_data,
  input  logic [CW-1:0] src_cnt,
  output logic          dst_rdy,
  input  logic          dst_ack,
  output logic [DW-1:0] dst_data,
  output logic [CW-1:0] dst_idx,
  output logic          dst_first,
  output logic          dst_last,
  output logic          busy
);

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] idx_q, idx_d;

  logic emit;
  logic is_last;
  logic src_xfer;

  assign emit = (state_q == StEmit);
  // cnt_q is never zero in StEmit, so cnt_q - 1 cannot wrap.
  assign is_last = emit && (idx_q == (cnt_q - CW'(1)));
  assign src_xfer = src_rdy && src_ack;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    src_ack = 1'b0;
    dst_rdy = 1'b0;

    case (state_q)
      StIdle: begin
        src_ack = src_rdy;
      end
      StEmit: begin
        dst_rdy = 1'b1;
        src_ack = src_rdy && dst_ack && is_last;
        if (dst_ack) begin
          if (is_last) begin
            state_d = StIdle;
          end else begin
            idx_d = idx_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A new token overrides whatever the current beat decided.
    if (src_xfer) begin
      if (src_cnt != '0) begin
        state_d = StEmit;
        data_d  = src_data;
        cnt_d   = src_cnt;
        idx_d   = '0;
      end else begin
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= StIdle;
      data_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Beat fields read as zero whenever no token is held.
  always_comb begin
    dst_data  = emit ? data_q : '0;
    dst_idx   = emit ? idx_q : '0;
    dst_first = emit && (idx_q == '0);
    dst_last  = is_last;
    busy      = dst_rdy;
  end

endmodule

// File: tb/tb_burst_repeat.sv
// Directed bench for burst_repeat: reset, single burst, back-to-back, zero count, stalls,
// mid-burst reset and a full-length burst on a narrow-count instance.
module tb_burst_repeat;

  localparam int DW = 16;
  localparam int CW = 8;
  localparam int DW4 = 8;
  localparam int CW4 = 4;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  logic          src_rdy, src_ack, dst_rdy, dst_ack, dst_first, dst_last, busy;
  logic [DW-1:0] src_data, dst_data;
  logic [CW-1:0] src_cnt, dst_idx;

  logic           s4_src_rdy, s4_src_ack, s4_dst_rdy, s4_dst_ack, s4_dst_first, s4_dst_last;
  logic           s4_busy;
  logic [DW4-1:0] s4_src_data, s4_dst_data;
  logic [CW4-1:0] s4_src_cnt, s4_dst_idx;

  int checks = 0;
  int errors = 0;

  burst_repeat #(.DW(DW), .CW(CW)) u_dut (
    .i_clk     (clk),
    .i_rstn    (rstn),
    .src_rdy   (src_rdy),
    .src_ack   (src_ack),
    .src_data  (src_data),
    .src_cnt   (src_cnt),
    .dst_rdy   (dst_rdy),
    .dst_ack   (dst_ack),
    .dst_data  (dst_data),
    .dst_idx   (dst_idx),
    .dst_first (dst_first),
    .dst_last  (dst_last),
    .busy      (busy)
  );

  burst_repeat #(.DW(DW4), .CW(CW4)) u_dut4 (
    .i_clk     (clk),
    .i_rstn    (rstn),
    .src_rdy   (s4_src_rdy),
    .src_ack   (s4_src_ack),
    .src_data  (s4_src_data),
    .src_cnt   (s4_src_cnt),
    .dst_rdy   (s4_dst_rdy),
    .dst_ack   (s4_dst_ack),
    .dst_data  (s4_dst_data),
    .dst_idx   (s4_dst_idx),
    .dst_first (s4_dst_first),
    .dst_last  (s4_dst_last),
    .busy      (s4_busy)
  );

  task automatic test_reset();
    #1 rstn = 1'b0;
    @(negedge clk);
    checks++; if (dst_rdy !== 1'b0) begin errors++; $display("FAIL reset_dst_rdy: got %b expected 0", dst_rdy); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (dst_idx !== '0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", dst_idx); end
    checks++; if (dst_first !== 1'b0) begin errors++; $display("FAIL reset_first: got %b expected 0", dst_first); end
    checks++; if (dst_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", dst_last); end
    checks++; if (dst_data !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", dst_data); end
    checks++; if (src_ack !== 1'b0) begin errors++; $display("FAIL reset_src_ack_lo: got %b expected 0", src_ack); end
    checks++; if (s4_dst_rdy !== 1'b0) begin errors++; $display("FAIL reset_dut4_rdy: got %b expected 0", s4_dst_rdy); end
    src_rdy = 1'b1;
    #1;
    checks++; if (src_ack !== 1'b1) begin errors++; $display("FAIL reset_src_ack_follow: got %b expected 1", src_ack); end
    src_rdy = 1'b0;
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk);
    checks++; if (dst_rdy !== 1'b0) begin errors++; $display("FAIL reset_release_rdy: got %b expected 0", dst_rdy); end
  endtask

  task automatic test_single();
    src_rdy = 1'b1; src_data = 16'h00AB; src_cnt = 8'd3; dst_ack = 1'b1;
    #1;
    checks++; if (src_ack !== 1'b1) begin errors++; $display("FAIL single_src_ack: got %b expected 1", src_ack); end
    checks++; if (dst_rdy !== 1'b0) begin errors++; $display("FAIL single_pre_rdy: got %b expected 0", dst_rdy); end
    @(posedge clk); #1;
    // Payload changes outside a transfer must be ignored.
    src_rdy = 1'b0; src_data = 16'hDEAD; src_cnt = 8'd9;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (dst_rdy !== 1'b1) begin errors++; $display("FAIL single_rdy[%0d]: got %b expected 1", i, dst_rdy); end
      checks++; if (dst_idx !== CW'(i)) begin errors++; $display("FAIL single_idx[%0d]: got %0d expected %0d", i, dst_idx, i); end
      checks++; if (dst_data !== 16'h00AB) begin errors++; $display("FAIL single_data[%0d]: got %h expected 00ab", i, dst_data); end
      checks++; if (dst_first !== (i == 0)) begin errors++; $display("FAIL single_first[%0d]: got %b expected %b", i, dst_first, (i == 0)); end
      checks++; if (dst_last !== (i == 2)) begin errors++; $display("FAIL single_last[%0d]: got %b expected %b", i, dst_last, (i == 2)); end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++; if (dst_rdy !== 1'b0) begin errors++; $display("FAIL single_idle_rdy: got %b expected 0", dst_rdy); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_data [4];
    int            exp_idx  [4];
    exp_data = '{16'h1111, 16'h1111, 16'h2222, 16'h2222};
    exp_idx  = '{0, 1, 0, 1};
    src_rdy = 1'b1; src_data = 16'h1111; src_cnt = 8'd2; dst_ack = 1'b1;
    #1;
    checks++; if (src_ack !== 1'b1) begin errors++; $display("FAIL b2b_first_ack: got %b expected 1", src_ack); end
    @(posedge clk); #1;
    src_data = 16'h2222; src_cnt = 8'd2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (dst_rdy !== 1'b1) begin errors++; $display("FAIL b2b_rdy[%0d]: got %b expected 1", i, dst_rdy); end
      checks++; if (dst_data !== exp_data[i]) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, dst_data, exp_data[i]); end
      checks++; if (dst_idx !== CW'(exp_idx[i])) begin errors++; $display("FAIL b2b_idx[%0d]: got %0d expected %0d", i, dst_idx, exp_idx[i]); end
      checks++; if (src_ack !== (i == 1)) begin errors++; $display("FAIL b2b_src_ack[%0d]: got %b expected %b", i, src_ack, (i == 1)); end
      @(posedge clk); #1;
      if (i == 1) src_rdy = 1'b0;
    end
    @(negedge clk);
    checks++; if (dst_rdy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b expected 0", dst_rdy); end
  endtask

  task automatic test_zero_cnt();
    src_rdy = 1'b1; src_data = 16'h9999; src_cnt = 8'd0; dst_ack = 1'b1;
    #1;
    checks++; if (src_ack !== 1'b1) begin errors++; $display("FAIL zero_ack: got %b expected 1", src_ack); end
    @(posedge clk); #1;
    src_data = 16'h0005; src_cnt = 8'd1;
    @(negedge clk);
    checks++; if (dst_rdy !== 1'b0) begin errors++; $display("FAIL zero_no_beat: got %b expected 0", dst_rdy); end
    checks++; if (src_ack !== 1'b1) begin errors++; $display("FAIL zero_next_ack: got %b expected 1", src_ack); end
    @(posedge clk); #1;
    src_rdy = 1'b0;
    @(negedge clk);
    checks++; if (dst_rdy !== 1'b1) begin errors++; $display("FAIL one_rdy: got %b expected 1", dst_rdy); end
    checks++; if (dst_data !== 16'h0005) begin errors++; $display("FAIL one_data: got %h expected 0005", dst_data); end
    checks++; if (dst_idx !== '0) begin errors++; $display("FAIL one_idx: got %0d expected 0", dst_idx); end
    checks++; if (dst_first !== 1'b1 || dst_last !== 1'b1) begin errors++; $display("FAIL one_first_last: got %b%b expected 11", dst_first, dst_last); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (dst_rdy !== 1'b0) begin errors++; $display("FAIL one_idle: got %b expected 0", dst_rdy); end
  endtask

  task automatic test_stall();
    logic ack_seq [7];
    int   exp_idx [7];
    int   beats;
    ack_seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    exp_idx = '{0, 1, 1, 1, 2, 2, 3};
    beats = 0;
    src_rdy = 1'b1; src_data = 16'h4444; src_cnt = 8'd4; dst_ack = 1'b0;
    #1;
    checks++; if (src_ack !== 1'b1) begin errors++; $display("FAIL stall_accept: got %b expected 1", src_ack); end
    @(posedge clk); #1;
    // A waiting zero-count token shows when src_ack is released without adding beats.
    src_data = 16'h7777; src_cnt = 8'd0;
    for (int i = 0; i < 7; i++) begin
      dst_ack = ack_seq[i];
      @(negedge clk);
      checks++; if (dst_rdy !== 1'b1) begin errors++; $display("FAIL stall_rdy[%0d]: got %b expected 1", i, dst_rdy); end
      checks++; if (dst_idx !== CW'(exp_idx[i])) begin errors++; $display("FAIL stall_idx[%0d]: got %0d expected %0d", i, dst_idx, exp_idx[i]); end
      checks++; if (dst_data !== 16'h4444) begin errors++; $display("FAIL stall_data[%0d]: got %h expected 4444", i, dst_data); end
      checks++; if (dst_last !== (exp_idx[i] == 3)) begin errors++; $display("FAIL stall_last[%0d]: got %b expected %b", i, dst_last, (exp_idx[i] == 3)); end
      checks++; if (src_ack !== (i == 6)) begin errors++; $display("FAIL stall_src_ack[%0d]: got %b expected %b", i, src_ack, (i == 6)); end
      if (dst_rdy && dst_ack) beats++;
      @(posedge clk); #1;
    end
    src_rdy = 1'b0; dst_ack = 1'b0;
    checks++; if (beats !== 4) begin errors++; $display("FAIL stall_beats: got %0d expected 4", beats); end
    @(negedge clk);
    checks++; if (dst_rdy !== 1'b0) begin errors++; $display("FAIL stall_idle: got %b expected 0", dst_rdy); end
  endtask

  task automatic test_reset_mid();
    src_rdy = 1'b1; src_data = 16'h5555; src_cnt = 8'd5; dst_ack = 1'b1;
    @(posedge clk); #1;
    src_rdy = 1'b0;
    @(negedge clk);
    checks++; if (dst_idx !== 8'd0) begin errors++; $display("FAIL rmid_idx0: got %0d expected 0", dst_idx); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (dst_idx !== 8'd1 || dst_rdy !== 1'b1) begin errors++; $display("FAIL rmid_idx1: got idx %0d rdy %b expected idx 1 rdy 1", dst_idx, dst_rdy); end
    rstn = 1'b0;
    #1;
    checks++; if (dst_rdy !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_rdy: got %b%b expected 00", dst_rdy, busy); end
    checks++; if (dst_idx !== '0 || dst_data !== '0) begin errors++; $display("FAIL rmid_fields: got idx %0d data %h expected 0 0", dst_idx, dst_data); end
    checks++; if (dst_first !== 1'b0 || dst_last !== 1'b0) begin errors++; $display("FAIL rmid_flags: got %b%b expected 00", dst_first, dst_last); end
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (dst_rdy !== 1'b0) begin errors++; $display("FAIL rmid_residual[%0d]: got %b expected 0", i, dst_rdy); end
      @(posedge clk); #1;
    end
    src_rdy = 1'b1; src_data = 16'h6666; src_cnt = 8'd2;
    @(posedge clk); #1;
    src_rdy = 1'b0;
    @(negedge clk);
    checks++; if (dst_idx !== 8'd0 || dst_first !== 1'b1) begin errors++; $display("FAIL rmid_restart_idx: got idx %0d first %b expected 0 1", dst_idx, dst_first); end
    checks++; if (dst_data !== 16'h6666) begin errors++; $display("FAIL rmid_restart_data: got %h expected 6666", dst_data); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (dst_idx !== 8'd1 || dst_last !== 1'b1) begin errors++; $display("FAIL rmid_restart_last: got idx %0d last %b expected 1 1", dst_idx, dst_last); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (dst_rdy !== 1'b0) begin errors++; $display("FAIL rmid_idle: got %b expected 0", dst_rdy); end
  endtask

  task automatic test_cw4_max();
    int beats;
    beats = 0;
    s4_src_rdy = 1'b1; s4_src_data = 8'h3C; s4_src_cnt = 4'd15; s4_dst_ack = 1'b1;
    @(posedge clk); #1;
    s4_src_rdy = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      checks++; if (s4_dst_rdy !== 1'b1) begin errors++; $display("FAIL cw4_rdy[%0d]: got %b expected 1", i, s4_dst_rdy); end
      checks++; if (s4_dst_idx !== CW4'(i)) begin errors++; $display("FAIL cw4_idx[%0d]: got %0d expected %0d", i, s4_dst_idx, i); end
      checks++; if (s4_dst_last !== (i == 14)) begin errors++; $display("FAIL cw4_last[%0d]: got %b expected %b", i, s4_dst_last, (i == 14)); end
      checks++; if (s4_dst_data !== 8'h3C) begin errors++; $display("FAIL cw4_data[%0d]: got %h expected 3c", i, s4_dst_data); end
      if (s4_dst_rdy && s4_dst_ack) beats++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++; if (s4_dst_rdy !== 1'b0) begin errors++; $display("FAIL cw4_idle: got %b expected 0", s4_dst_rdy); end
    checks++; if (beats !== 15) begin errors++; $display("FAIL cw4_beats: got %0d expected 15", beats); end
  endtask

  initial begin
    src_rdy = 1'b0; src_data = '0; src_cnt = '0; dst_ack = 1'b0;
    s4_src_rdy = 1'b0; s4_src_data = '0; s4_src_cnt = '0; s4_dst_ack = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_zero_cnt();
    test_stall();
    test_reset_mid();
    test_cw4_max();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
